// File: rtl/ecg_bpm_calc_if.sv
// Beat-rate calculator bus: detector strobes in, heart-rate result and status out.
interface ecg_bpm_calc_if;
    logic       sample_tick;
    logic       r_peak;
    logic [7:0] bpm_out;
    logic       bpm_valid;
    logic       no_beat;
    logic       busy;

    // Producer of strobes / consumer of the rate.
    modport master (
        output sample_tick,
        output r_peak,
        input  bpm_out,
        input  bpm_valid,
        input  no_beat,
        input  busy
    );

    // The calculator itself.
    modport slave (
        input  sample_tick,
        input  r_peak,
        output bpm_out,
        output bpm_valid,
        output no_beat,
        output busy
    );
endinterface

// File: rtl/ecg_bpm_calc.sv
// Heart-rate calculator: measures R-R interval in sample ticks and divides
// 60*FS by it with a sequential restoring divider to produce beats per minute.
module ecg_bpm_calc #(
    parameter int unsigned FS      = 360,
    parameter int unsigned MIN_BPM = 30,
    parameter int unsigned MAX_BPM = 250,
    parameter int unsigned CW      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    ecg_bpm_calc_if.slave  bus
);

    localparam int unsigned DIVIDEND = 60 * FS;
    localparam int unsigned INT_MAX  = DIVIDEND / MIN_BPM;
    localparam int unsigned INT_MIN  = DIVIDEND / MAX_BPM;
    localparam int unsigned SW       = $clog2(CW);

    localparam logic [CW-1:0] DIVIDEND_C = CW'(DIVIDEND);
    localparam logic [CW-1:0] INT_MAX_C  = CW'(INT_MAX);
    localparam logic [CW-1:0] INT_MIN_C  = CW'(INT_MIN);
    localparam logic [CW-1:0] CNT_SAT    = CW'(INT_MAX + 1);
    localparam logic [CW-1:0] BPM_MAX_C  = CW'(255);
    localparam logic [SW-1:0] LAST_STEP  = SW'(CW - 1);

    localparam logic [1:0] WAIT_FIRST = 2'd0;
    localparam logic [1:0] COUNT      = 2'd1;
    localparam logic [1:0] DIV        = 2'd2;
    localparam logic [1:0] DONE       = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] dvsr;
    logic [CW-1:0] rem;
    logic [CW-1:0] quo;
    logic [SW-1:0] step;
    logic [7:0]    bpm_q;
    logic          bpm_valid_q;
    logic          no_beat_q;
    logic          busy_q;

    logic          accept_c;
    logic          timeout_c;
    logic          in_range_c;
    logic [CW:0]   shifted_c;
    logic          fits_c;
    logic [CW-1:0] rem_nxt_c;
    logic [7:0]    bpm_sat_c;

    // Next-state decode; an accepted peak outranks the timeout check.
    always_comb begin
        state_nxt  = state;
        accept_c   = 1'b0;
        timeout_c  = 1'b0;
        in_range_c = (cnt >= INT_MIN_C) && (cnt <= INT_MAX_C);
        case (state)
            WAIT_FIRST: begin
                if (bus.r_peak) state_nxt = COUNT;
            end
            COUNT: begin
                if (bus.r_peak && in_range_c) begin
                    accept_c  = 1'b1;
                    state_nxt = DIV;
                end else if (bus.sample_tick && (cnt == INT_MAX_C)) begin
                    timeout_c = 1'b1;
                    state_nxt = WAIT_FIRST;
                end
            end
            DIV: begin
                if (step == LAST_STEP) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = COUNT;
            end
            default: begin
                state_nxt = WAIT_FIRST;
            end
        endcase
    end

    // Interval counter: saturating tick count, restarted by a starting or accepted peak.
    always_comb begin
        cnt_nxt = cnt;
        if ((state != WAIT_FIRST) && bus.sample_tick && (cnt != CNT_SAT))
            cnt_nxt = cnt + CW'(1);
        if (((state == WAIT_FIRST) && bus.r_peak) || accept_c)
            cnt_nxt = '0;
    end

    // One restoring-division step; dividend bits shift out of quo's MSB as quotient bits shift in.
    always_comb begin
        shifted_c = {rem, quo[CW-1]};
        fits_c    = (shifted_c >= {1'b0, dvsr});
        rem_nxt_c = fits_c ? CW'(shifted_c - {1'b0, dvsr}) : shifted_c[CW-1:0];
        bpm_sat_c = (quo > BPM_MAX_C) ? 8'hFF : quo[7:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_FIRST;
        else        state <= state_nxt;
    end

    // Counter and divider datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dvsr <= '0;
            rem  <= '0;
            quo  <= '0;
            step <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (accept_c) begin
                dvsr <= cnt;
                rem  <= '0;
                quo  <= DIVIDEND_C;
                step <= '0;
            end else if (state == DIV) begin
                rem  <= rem_nxt_c;
                quo  <= {quo[CW-2:0], fits_c};
                step <= step + SW'(1);
            end
        end
    end

    // Registered outputs: result publish, timeout, and divider-busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
            no_beat_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bpm_valid_q <= 1'b0;
            busy_q      <= (state_nxt == DIV);
            if (timeout_c) begin
                bpm_q       <= '0;
                no_beat_q   <= 1'b1;
                bpm_valid_q <= 1'b1;
            end else if (state == DONE) begin
                bpm_q       <= bpm_sat_c;
                no_beat_q   <= 1'b0;
                bpm_valid_q <= 1'b1;
            end
        end
    end

    assign bus.bpm_out   = bpm_q;
    assign bus.bpm_valid = bpm_valid_q;
    assign bus.no_beat   = no_beat_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ecg_bpm_calc.sv
// Directed bench for ecg_bpm_calc with a scoreboard of expected rate publications.
module tb_ecg_bpm_calc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ecg_bpm_calc_if bus ();

    ecg_bpm_calc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]  bpm;
        logic        nb;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   last_edge = 0;
    int   busy_cyc  = 0;
    int   checks    = 0;
    int   passed    = 0;
    int   fails     = 0;
    int   b0        = 0;

    // Edge counter: holds the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Number of cycles busy was seen high.
    always @(negedge clk) if (bus.busy === 1'b1) busy_cyc <= busy_cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Apply inputs for exactly one rising edge; last_edge records that edge.
    task automatic step(input logic t, input logic p);
        bus.sample_tick = t;
        bus.r_peak      = p;
        @(posedge clk);
        #1;
        last_edge       = cyc;
        bus.sample_tick = 1'b0;
        bus.r_peak      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic expect_res(input logic [7:0] bpm, input logic nb, input int lat);
        exp_t e;
        e.bpm = bpm;
        e.nb  = nb;
        e.cyc = 32'(last_edge + lat);
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.bpm_valid === 1'b1) begin
            check("valid_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("bpm_out", 32'(bus.bpm_out), 32'(e.bpm));
                check("no_beat", 32'(bus.no_beat), 32'(e.nb));
                check("valid_cycle", 32'(cyc), e.cyc);
            end
        end
    end

    initial begin
        bus.sample_tick = 1'b0;
        bus.r_peak      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bpm_out", 32'(bus.bpm_out), 32'd0);
        check("rst_bpm_valid", 32'(bus.bpm_valid), 32'd0);
        check("rst_no_beat", 32'(bus.no_beat), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 360-tick interval -> 60 bpm, 17-clk latency, 16 busy cycles.
        ticks(5);
        step(1'b0, 1'b1);
        ticks(360);
        b0 = busy_cyc;
        step(1'b0, 1'b1);
        expect_res(8'd60, 1'b0, 17);
        check("busy_after_peak", 32'(bus.busy), 32'd1);

        // Lower interval bound 86 -> 251.
        ticks(86);
        check("busy_cycles", 32'(busy_cyc - b0), 32'd16);
        step(1'b0, 1'b1);
        expect_res(8'd251, 1'b0, 17);

        // Upper interval bound 720 -> 30.
        ticks(720);
        step(1'b0, 1'b1);
        expect_res(8'd30, 1'b0, 17);

        // Refractory peak at tick 50 is ignored; 180 -> 120.
        ticks(50);
        step(1'b0, 1'b1);
        check("refractory_no_div", 32'(bus.busy), 32'd0);
        ticks(130);
        step(1'b0, 1'b1);
        expect_res(8'd120, 1'b0, 17);

        // Timeout on the tick that would reach 721.
        ticks(720);
        step(1'b1, 1'b0);
        expect_res(8'd0, 1'b1, 0);
        check("timeout_no_beat", 32'(bus.no_beat), 32'd1);
        check("timeout_bpm", 32'(bus.bpm_out), 32'd0);
        ticks(10);
        step(1'b0, 1'b1);
        ticks(432);
        step(1'b0, 1'b1);
        expect_res(8'd50, 1'b0, 17);

        // Coincident tick and peak after 200 ticks -> 108; the tick is not counted.
        ticks(200);
        step(1'b1, 1'b1);
        expect_res(8'd108, 1'b0, 17);
        ticks(240);
        step(1'b0, 1'b1);
        expect_res(8'd90, 1'b0, 17);

        // Reset during division aborts it.
        ticks(300);
        check("held_bpm", 32'(bus.bpm_out), 32'd90);
        step(1'b0, 1'b1);
        idle(7);
        check("busy_mid_div", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_bpm", 32'(bus.bpm_out), 32'd0);
        check("async_rst_valid", 32'(bus.bpm_valid), 32'd0);
        check("async_rst_no_beat", 32'(bus.no_beat), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(25);
        ticks(15);
        step(1'b0, 1'b1);
        ticks(100);
        idle(20);
        check("first_peak_no_div", 32'(bus.busy), 32'd0);
        step(1'b0, 1'b1);
        expect_res(8'd216, 1'b0, 17);

        // Extra peaks during division are ignored; the tick inside DIV is kept.
        ticks(150);
        step(1'b0, 1'b1);
        expect_res(8'd144, 1'b0, 17);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        check("busy_with_peaks", 32'(bus.busy), 32'd1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        idle(10);
        ticks(99);
        step(1'b0, 1'b1);
        expect_res(8'd216, 1'b0, 17);

        // Drain the scoreboard within a bounded wait.
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ecg_bpm_calc.md
# ecg_bpm_calc

Heart-rate calculator for the ECG pipeline. It measures the number of sample ticks between successive R-peak strobes from the QRS detector and divides 60·FS by that interval with a sequential restoring divider. It publishes an 8-bit beats-per-minute value, which the 8-bit binary-to-BCD converter feeding the display consumes directly. It also rejects physiologically impossible intervals and flags loss of beat.

## Interface
- `FS`, 360: ECG sample rate in Hz; `sample_tick` rate.
- `MIN_BPM`, 30: slowest valid rate. `INT_MAX` = 60·FS/MIN_BPM (integer division), 720 at defaults.
- `MAX_BPM`, 250: fastest valid rate. `INT_MIN` = 60·FS/MAX_BPM (integer division), 86 at defaults.
- `CW`, 16: width of the interval counter, dividend and divisor; 60·FS must fit in CW bits.

- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_tick` in 1: one-clk strobe per ECG sample.
- `r_peak` in 1: one-clk strobe from the QRS detector.
- `bpm_out` out 8: last computed heart rate, held between updates; feeds the BCD converter.
- `bpm_valid` out 1: one-clk pulse when `bpm_out` has just been written.
- `no_beat` out 1: high after a timeout; cleared by the next valid rate.
- `busy` out 1: high while the divider runs.

## Operation
- Interval counter `cnt` (CW bits) counts `sample_tick` in every state except WAIT_FIRST. It saturates at INT_MAX+1.
- **WAIT_FIRST** (reset state):
  - Ticks are ignored.
  - `r_peak` → `cnt`=0, go to COUNT.
- **COUNT**, priority order per edge:
  - If `r_peak` and `cnt` < INT_MIN: the peak is ignored (refractory). `cnt` keeps counting.
  - If `r_peak` and INT_MIN ≤ `cnt` ≤ INT_MAX:
    - Latch divisor = `cnt`.
    - `cnt`=0. A simultaneous `sample_tick` is not counted.
    - Go to DIV.
  - Else if `sample_tick` would take `cnt` to INT_MAX+1 (timeout):
    - `bpm_out`=0, `no_beat`=1, `bpm_valid` pulse.
    - Go to WAIT_FIRST.
- **DIV**:
  - Restoring division of the constant 60·FS by the divisor, one quotient bit per clk, CW clks.
  - `busy`=1.
  - `r_peak` is ignored. `sample_tick` is still counted into `cnt`.
- **DONE** (1 clk):
  - `bpm_out` = quotient truncated toward zero, saturated to 255.
  - `no_beat`=0, `bpm_valid`=1.
  - Go to COUNT.
- Arithmetic rules:
  - Divisor ≥ INT_MIN ≥ 1, so the divider never divides by zero.
  - Quotient ≤ 60·FS/INT_MIN. This fits 8 bits at defaults; the saturation covers other parameter sets.
- Reset, including mid-DIV:
  - State goes to WAIT_FIRST; `cnt`, divisor, remainder and quotient are cleared.
  - `bpm_out`=0, `bpm_valid`=0, `no_beat`=0, `busy`=0.
  - No `bpm_valid` is produced for an aborted division.

## Timing
- Let edge E be the clk edge that samples an accepted `r_peak`.
- DIV occupies edges E+1..E+CW.
- DONE writes `bpm_out` and `bpm_valid` at edge E+CW+1; that is E+17 at CW=16.
- `bpm_valid` is high for exactly one cycle. `bpm_out` is stable from that edge until the next update.
- `busy` is high from E+1 through E+CW and low in DONE.
- Timeout: `bpm_out`=0 and `bpm_valid` register on the same edge that samples the offending `sample_tick`.
- Input constraint: the clk frequency exceeds FS·(CW+2), so a tick and an accepted peak cannot both fall inside DIV. The counter still counts ticks during DIV, so no tick is lost.

## Test plan
- Reset; `r_peak`; 360 ticks; `r_peak` → `bpm_out`=60, `bpm_valid` pulse exactly 17 clks after the second peak edge, `busy` high for 16 clks.
- Interval exactly 86 → 251. Interval exactly 720 → 30. Peaks at tick 0, tick 50 (ignored, no valid pulse) and tick 180 → 120.
- Peak then no peak → on the tick that takes `cnt` to 721: `bpm_out`=0, `no_beat`=1, one valid pulse. Two more peaks 432 ticks apart → 50, `no_beat`=0.
- `r_peak` and `sample_tick` on the same edge after 200 ticks → 108. The next interval is measured from 0, with the coincident tick excluded.
- `rst_n` low at clk 8 of DIV → all outputs 0 asynchronously, no valid pulse after release. The state is WAIT_FIRST: the next single peak produces no output.
- Repeated `r_peak` strobes during DIV → ignored, the result is unchanged, and `cnt` is still correct at DONE.
